// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller with a req/ack memory handshake,
// a request timeout, and sticky illegal-instruction and bus-error traps.
module mc_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       pcwrite_cond,
   output logic       regwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       extop,
   output logic       retire,
   output logic       illegal,
   output logic       bus_err
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC_R, RWB, EXEC_I, IWB, BRANCH, JUMP, TRAP
   } state_t;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010;
   localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011;
   state_t state, state_nx;
   logic [TO_W-1:0] cnt;
   logic req_st, timeout, r_ok, is_ori, set_ill, set_bus;
   assign req_st  = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   // The wait that would make MEM_TIMEOUT unacknowledged request cycles traps instead
   assign timeout = (MEM_TIMEOUT != 0) && req_st && !mem_ack && (cnt == TO_W'(MEM_TIMEOUT - 1));
   assign r_ok    = (opcode == OP_R) && ((funct == F_ADDU) || (funct == F_SUBU));
   assign is_ori  = (opcode == OP_ORI);
   always_comb begin
      state_nx     = state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      iord         = 1'b0;
      irwrite      = 1'b0;
      pcwrite      = 1'b0;
      pcwrite_cond = 1'b0;
      regwrite     = 1'b0;
      regdst       = 1'b0;
      memtoreg     = 1'b0;
      alusrca      = 1'b0;
      alusrcb      = 2'b00;
      aluop        = 2'b00;
      pcsrc        = 2'b00;
      extop        = 1'b0;
      retire       = 1'b0;
      set_ill      = 1'b0;
      set_bus      = 1'b0;
      case (state)
         IDLE: state_nx = FETCH;
         FETCH: begin
            mem_req  = 1'b1;
            alusrcb  = 2'b01;
            irwrite  = mem_ack;
            pcwrite  = mem_ack;
            state_nx = mem_ack ? DECODE : FETCH;
         end
         DECODE: begin
            alusrcb  = 2'b11;
            extop    = 1'b1;
            state_nx = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                       r_ok ? EXEC_R :
                       (opcode == OP_ADDI || is_ori) ? EXEC_I :
                       (opcode == OP_BEQ) ? BRANCH :
                       (opcode == OP_J) ? JUMP : TRAP;
            set_ill  = (state_nx == TRAP);
         end
         MEMADR: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            extop    = 1'b1;
            state_nx = (opcode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req  = 1'b1;
            iord     = 1'b1;
            state_nx = mem_ack ? MEMWB : MEMRD;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
            retire   = 1'b1;
            state_nx = FETCH;
         end
         MEMWR: begin
            mem_req  = 1'b1;
            mem_we   = 1'b1;
            iord     = 1'b1;
            retire   = mem_ack;
            state_nx = mem_ack ? FETCH : MEMWR;
         end
         EXEC_R: begin
            alusrca  = 1'b1;
            aluop    = 2'b10;
            state_nx = RWB;
         end
         RWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
            retire   = 1'b1;
            state_nx = FETCH;
         end
         EXEC_I: begin
            alusrca  = 1'b1;
            alusrcb  = 2'b10;
            aluop    = is_ori ? 2'b11 : 2'b00;
            extop    = !is_ori;
            state_nx = IWB;
         end
         IWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            aluop    = is_ori ? 2'b11 : 2'b00;
            extop    = !is_ori;
            state_nx = FETCH;
         end
         BRANCH: begin
            alusrca      = 1'b1;
            aluop        = 2'b01;
            pcsrc        = 2'b01;
            pcwrite_cond = 1'b1;
            retire       = 1'b1;
            state_nx     = FETCH;
         end
         JUMP: begin
            pcsrc    = 2'b10;
            pcwrite  = 1'b1;
            retire   = 1'b1;
            state_nx = FETCH;
         end
         TRAP: state_nx = TRAP;
         default: state_nx = IDLE;
      endcase
      if (timeout) begin
         state_nx = TRAP;
         set_bus  = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         cnt     <= '0;
         illegal <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= (req_st && !mem_ack) ? cnt + 1'b1 : '0;
         illegal <= illegal | set_ill;
         bus_err <= bus_err | set_bus;
      end
   end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: expands each instruction into its expected per-cycle output
// waveform and checks the controller cycle by cycle under random memory waits.
module tb_mc_ctrl;
   logic       clk = 1'b0, resetn = 1'b0, mem_ack = 1'b0;
   logic [5:0] opcode = '0, funct = '0;
   logic       mem_req, mem_we, iord, irwrite, pcwrite, pcwrite_cond;
   logic       regwrite, regdst, memtoreg, alusrca, extop, retire, illegal, bus_err;
   logic [1:0] alusrcb, aluop, pcsrc;
   always #5 clk = ~clk;
   mc_ctrl #(.MEM_TIMEOUT(4), .TO_W(4)) dut (
      .clk(clk), .resetn(resetn), .opcode(opcode), .funct(funct), .mem_ack(mem_ack),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .irwrite(irwrite),
      .pcwrite(pcwrite), .pcwrite_cond(pcwrite_cond), .regwrite(regwrite),
      .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .pcsrc(pcsrc), .extop(extop), .retire(retire),
      .illegal(illegal), .bus_err(bus_err)
   );
   typedef struct packed {
      logic req, we, iord, irw, pcw, pcwc, rw, rdst, m2r, asa;
      logic [1:0] asb, aop, psrc;
      logic ext, ret, ill, berr;
   } ov_t;
   typedef struct packed {
      ov_t e;
      logic a;
      logic [5:0] op, fn;
   } cyc_t;
   localparam int K_LW = 0, K_SW = 1, K_ADDU = 2, K_SUBU = 3, K_ADDI = 4, K_ORI = 5, K_BEQ = 6, K_J = 7;
   ov_t obs;
   assign obs = {mem_req, mem_we, iord, irwrite, pcwrite, pcwrite_cond, regwrite, regdst,
                 memtoreg, alusrca, alusrcb, aluop, pcsrc, extop, retire, illegal, bus_err};
   cyc_t  q[$];
   string tq[$];
   int n_chk = 0, n_pass = 0, n_ret = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      assert (got === want) n_pass++;
      else $error("FAIL %s got=%h want=%h", tag, got, want);
   endtask
   task automatic push(input string t, input ov_t e, input logic a, input logic [5:0] op, input logic [5:0] fn);
      cyc_t c;
      c.e = e; c.a = a; c.op = op; c.fn = fn;
      q.push_back(c);
      tq.push_back(t);
   endtask
   task automatic run();
      while (q.size() > 0) begin
         cyc_t c;
         string t;
         c = q.pop_front();
         t = tq.pop_front();
         @(negedge clk);
         mem_ack = c.a; opcode = c.op; funct = c.fn;
         #1;
         chk(t, 32'(obs), 32'(c.e));
         if (retire) n_ret++;
      end
   endtask
   task automatic do_reset();
      resetn = 1'b0; mem_ack = 1'b0;
      @(negedge clk); #1;
      chk("reset", 32'(obs), 32'd0);
      @(negedge clk); resetn = 1'b1; #1;
      chk("idle", 32'(obs), 32'd0);
   endtask
   task automatic gen_fd(input logic [5:0] op, input logic [5:0] fn, input int wf);
      ov_t v;
      v = '0; v.req = 1'b1; v.asb = 2'b01;
      for (int i = 0; i < wf; i++) push("fetch_wait", v, 1'b0, op, fn);
      v.irw = 1'b1; v.pcw = 1'b1;
      push("fetch_ack", v, 1'b1, op, fn);
      v = '0; v.asb = 2'b11; v.ext = 1'b1;
      push("decode", v, 1'($urandom), op, fn);
   endtask
   task automatic gen_trap(input int n, input logic ill, input logic be, input logic [5:0] op, input logic [5:0] fn);
      ov_t v;
      v = '0; v.ill = ill; v.berr = be;
      for (int i = 0; i < n; i++) push("trap", v, 1'($urandom), op, fn);
   endtask
   // wm >= 4 in a memory instruction means the data access never gets acked
   task automatic gen(input int k, input int wf, input int wm);
      logic [5:0] op, fn;
      ov_t v;
      op = k == K_LW ? 6'b100011 : k == K_SW ? 6'b101011 : k <= K_SUBU ? 6'b000000 :
           k == K_ADDI ? 6'b001000 : k == K_ORI ? 6'b001101 : k == K_BEQ ? 6'b000100 : 6'b000010;
      fn = k == K_ADDU ? 6'b100001 : k == K_SUBU ? 6'b100011 : 6'($urandom);
      gen_fd(op, fn, wf);
      v = '0;
      if (k == K_LW || k == K_SW) begin
         v.asa = 1'b1; v.asb = 2'b10; v.ext = 1'b1;
         push("memadr", v, 1'($urandom), op, fn);
         v = '0; v.req = 1'b1; v.iord = 1'b1; v.we = (k == K_SW);
         for (int i = 0; i < (wm >= 4 ? 4 : wm); i++) push("mem_wait", v, 1'b0, op, fn);
         if (wm >= 4) begin
            gen_trap(5, 1'b0, 1'b1, op, fn);
            return;
         end
         if (k == K_SW) begin
            v.ret = 1'b1;
            push("memwr_ack", v, 1'b1, op, fn);
         end else begin
            push("memrd_ack", v, 1'b1, op, fn);
            v = '0; v.rw = 1'b1; v.m2r = 1'b1; v.ret = 1'b1;
            push("memwb", v, 1'($urandom), op, fn);
         end
      end else if (k == K_ADDU || k == K_SUBU) begin
         v.asa = 1'b1; v.aop = 2'b10;
         push("exec_r", v, 1'($urandom), op, fn);
         v = '0; v.rw = 1'b1; v.rdst = 1'b1; v.ret = 1'b1;
         push("rwb", v, 1'($urandom), op, fn);
      end else if (k == K_ADDI || k == K_ORI) begin
         v.asa = 1'b1; v.asb = 2'b10; v.aop = (k == K_ORI) ? 2'b11 : 2'b00; v.ext = (k == K_ADDI);
         push("exec_i", v, 1'($urandom), op, fn);
         v.asa = 1'b0; v.asb = 2'b00; v.rw = 1'b1; v.ret = 1'b1;
         push("iwb", v, 1'($urandom), op, fn);
      end else if (k == K_BEQ) begin
         v.asa = 1'b1; v.aop = 2'b01; v.psrc = 2'b01; v.pcwc = 1'b1; v.ret = 1'b1;
         push("branch", v, 1'($urandom), op, fn);
      end else begin
         v.psrc = 2'b10; v.pcw = 1'b1; v.ret = 1'b1;
         push("jump", v, 1'($urandom), op, fn);
      end
   endtask
   initial begin
      do_reset();
      n_ret = 0;
      gen(K_ORI, 0, 0);
      run();
      chk("ori_retire_count", 32'(n_ret), 32'd1);
      gen(K_LW, 2, 1);
      run();
      gen(K_BEQ, 0, 0);
      gen(K_J, 1, 0);
      gen(K_ADDI, 0, 0);
      gen(K_ADDU, 0, 0);
      gen(K_SUBU, 2, 0);
      gen(K_SW, 0, 3);
      run();
      repeat (60) gen(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run();
      do_reset();
      gen_fd(6'b111111, 6'b000000, 1);
      gen_trap(20, 1'b1, 1'b0, 6'b111111, 6'b000000);
      run();
      do_reset();
      gen_fd(6'b000000, 6'b001000, 0);
      gen_trap(20, 1'b1, 1'b0, 6'b000000, 6'b001000);
      run();
      do_reset();
      gen_fd(6'b001000, 6'b0, 4);
      void'(q.pop_back()); void'(tq.pop_back());
      void'(q.pop_back()); void'(tq.pop_back());
      gen_trap(6, 1'b0, 1'b1, 6'b001000, 6'b0);
      run();
      do_reset();
      gen(K_ADDI, 3, 0);
      gen(K_LW, 0, 4);
      run();
      do_reset();
      gen(K_SW, 0, 2);
      void'(q.pop_back()); void'(tq.pop_back());
      run();
      #1 resetn = 1'b0;
      #1 chk("async_reset", 32'(obs), 32'd0);
      @(negedge clk); resetn = 1'b1; #1;
      chk("idle_after_async", 32'(obs), 32'd0);
      gen(K_SW, 1, 1);
      gen(K_LW, 0, 0);
      run();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
